paralelo_a_serie: RTL

// - Parallel-to-serial transmitter; the sending end of the serial link whose receiver rebuilds WIDTH-bit words.
// - Accepts one WIDTH-bit word through a valid/ready handshake and shifts it out, one bit per enabled clock.
// - Flags the first and last bit of each frame so the receiver side can realign its words.
// - Sits between the tile's input pins and the external serial line.

---
 rtl/paralelo_a_serie_if.sv | 26 ++
 rtl/paralelo_a_serie.sv | 129 ++++++++++++
 2 files changed

// File: rtl/paralelo_a_serie_if.sv
// Link bundle for paralelo_a_serie: the parallel load port plus the serial line outputs.
// Handshake: a word moves when load_valid and load_ready are both high at a rising clk edge;
// load_ready depends only on state, never on load_valid, and parallel_in matters only on that edge.
interface paralelo_a_serie_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             load_valid;
  logic [WIDTH-1:0] parallel_in;
  logic             load_ready;
  logic             serial_out;
  logic             serial_valid;
  logic             frame_start;
  logic             frame_last;
  logic             busy;

  modport master (
    output en, load_valid, parallel_in,
    input  load_ready, serial_out, serial_valid, frame_start, frame_last, busy
  );

  modport slave (
    input  en, load_valid, parallel_in,
    output load_ready, serial_out, serial_valid, frame_start, frame_last, busy
  );
endinterface

// File: rtl/paralelo_a_serie.sv
// Parallel-to-serial transmitter with first/last frame flags and enable-driven stalls.
// Optional macro PARITY_EN appends one even-parity bit to every frame.
module paralelo_a_serie #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  paralelo_a_serie_if.slave   link,
  output logic [1:0]          state_dbg
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int             CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  LAST_M1 = CW'(WIDTH - 2);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             serial_out_q;
  logic             serial_valid_q;
  logic             frame_start_q;
  logic             frame_last_q;
  logic             load_ready_q;
  logic             busy_q;
`ifdef PARITY_EN
  logic             par_bit;
`endif

  // The bit presented next always sits at the outgoing end of the register.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      sreg           <= '0;
      cnt            <= '0;
      serial_out_q   <= 1'b0;
      serial_valid_q <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_last_q   <= 1'b0;
      load_ready_q   <= 1'b1;
      busy_q         <= 1'b0;
`ifdef PARITY_EN
      par_bit        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // load_ready is high throughout IDLE, so load_valid alone completes the handshake.
          if (link.load_valid) begin
            state          <= SHIFT;
            sreg           <= advance(link.parallel_in);
            cnt            <= '0;
            serial_out_q   <= head(link.parallel_in);
            serial_valid_q <= 1'b1;
            frame_start_q  <= 1'b1;
            frame_last_q   <= 1'b0;
            load_ready_q   <= 1'b0;
            busy_q         <= 1'b1;
`ifdef PARITY_EN
            par_bit        <= ^link.parallel_in;
`endif
          end
        end
        SHIFT: begin
          if (link.en) begin
            frame_start_q <= 1'b0;
            if (cnt == LAST) begin
`ifdef PARITY_EN
              state        <= PARITY;
              serial_out_q <= par_bit;
              frame_last_q <= 1'b1;
`else
              state          <= IDLE;
              serial_out_q   <= 1'b0;
              serial_valid_q <= 1'b0;
              frame_last_q   <= 1'b0;
              load_ready_q   <= 1'b1;
              busy_q         <= 1'b0;
`endif
            end else begin
              cnt          <= cnt + 1'b1;
              serial_out_q <= head(sreg);
              sreg         <= advance(sreg);
`ifdef PARITY_EN
              frame_last_q <= 1'b0;
`else
              frame_last_q <= (cnt == LAST_M1);
`endif
            end
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          if (link.en) begin
            state          <= IDLE;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            frame_last_q   <= 1'b0;
            load_ready_q   <= 1'b1;
            busy_q         <= 1'b0;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign link.serial_out   = serial_out_q;
  assign link.serial_valid = serial_valid_q;
  assign link.frame_start  = frame_start_q;
  assign link.frame_last   = frame_last_q;
  assign link.load_ready   = load_ready_q;
  assign link.busy         = busy_q;
  assign state_dbg         = state;
endmodule
